// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_send transmitter among four byte requesters.
// It times each 8N1 frame itself, because uart_send has no busy flag, and only grants
// the next requester once the whole frame window (ten bit times plus a guard gap) has
// elapsed. Every output comes straight from a register.
module uart_tx_arbiter #(
  parameter logic [15:0] BPS_CNT    = 16'd434,  // sys_clk cycles per bit, same as uart_send
  parameter logic [15:0] GUARD_CLKS = 16'd4,    // idle gap appended after each frame
  parameter logic [3:0]  EN_HOLD    = 4'd2      // uart_en high time; uart_send needs >= 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        uart_en,
  output logic [7:0]  uart_din
);

  // Length of one frame window in cycles, counted from the first cycle uart_en is high.
  localparam int unsigned   FRAME_INT  = 10 * 32'(BPS_CNT) + 32'(GUARD_CLKS);
  localparam logic [23:0]   FRAME_CLKS = 24'(FRAME_INT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a request
    FIRE = 2'd1,  // holding uart_en high so uart_send sees a clean rising edge
    WAIT = 2'd2   // frame is on the wire; wait until the window closes
  } state_e;

  state_e      state_q,   state_d;
  logic [1:0]  rr_q,      rr_d;       // index of the requester served last
  logic [23:0] timer_q,   timer_d;    // cycles since the frame started; saturates
  logic [3:0]  en_cnt_q,  en_cnt_d;   // cycles uart_en has been high in this frame
  logic [3:0]  ack_q,     ack_d;
  logic [1:0]  grant_q,   grant_d;
  logic        busy_q,    busy_d;
  logic        uart_en_q, uart_en_d;
  logic [7:0]  din_q,     din_d;

  logic [1:0]  win;                   // requester that would win this cycle

  // Round-robin pick: first set request bit searching rr_q+1, rr_q+2, ... (mod 4).
  // The scan runs from the farthest candidate to the nearest so the nearest one
  // is the last assignment and therefore wins.
  always_comb begin
    win = rr_q;
    for (int k = 4; k >= 1; k--) begin
      if (req[rr_q + 2'(k)]) win = rr_q + 2'(k);
    end
  end

  // Next-state and next-output logic for the grant / frame-timing FSM.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves one
    // unassigned would make synthesis infer a latch to hold its old value.
    state_d   = state_q;
    rr_d      = rr_q;
    timer_d   = timer_q;
    en_cnt_d  = en_cnt_q;
    ack_d     = 4'b0000;          // ack is a single-cycle pulse
    grant_d   = grant_q;
    busy_d    = busy_q;
    uart_en_d = uart_en_q;
    din_d     = din_q;

    // The frame timer runs in FIRE and WAIT and stops at the window length.
    if (state_q != IDLE && timer_q != FRAME_CLKS) timer_d = timer_q + 24'd1;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          ack_d     = 4'b0001 << win;
          din_d     = req_data[{win, 3'b000} +: 8];
          grant_d   = win;
          rr_d      = win;
          busy_d    = 1'b1;
          uart_en_d = 1'b1;
          timer_d   = 24'd1;
          en_cnt_d  = 4'd1;
          state_d   = FIRE;
        end
      end
      FIRE: begin
        if (en_cnt_q >= EN_HOLD) begin
          uart_en_d = 1'b0;
          state_d   = WAIT;
        end else begin
          en_cnt_d  = en_cnt_q + 4'd1;
        end
      end
      WAIT: begin
        if (timer_q == FRAME_CLKS) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset puts requester 0 first in line.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      rr_q      <= 2'd3;
      timer_q   <= '0;
      en_cnt_q  <= '0;
      ack_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      uart_en_q <= 1'b0;
      din_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the values
      // of the previous cycle, regardless of statement order.
      state_q   <= state_d;
      rr_q      <= rr_d;
      timer_q   <= timer_d;
      en_cnt_q  <= en_cnt_d;
      ack_q     <= ack_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      uart_en_q <= uart_en_d;
      din_q     <= din_d;
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign uart_en  = uart_en_q;
  assign uart_din = din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural uart_send transmitter and a serial
// receiver on uart_txd, plus a round-robin reference model built on plain
// modulo-4 arithmetic over the request mask.
module tb_uart_tx_arbiter;

  localparam logic [15:0] BPS_CNT    = 16'd8;
  localparam logic [15:0] GUARD_CLKS = 16'd4;
  localparam logic [3:0]  EN_HOLD    = 4'd2;
  localparam int          BPS        = 8;
  localparam int          FRAME      = 10 * BPS + 4;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        uart_en;
  logic [7:0]  uart_din;

  int checks = 0;
  int errors = 0;
  int model_rr = 3;

  logic [7:0] rx_q[$];
  logic       rx_start_q[$];
  logic       rx_stop_q[$];

  uart_tx_arbiter #(
    .BPS_CNT    (BPS_CNT),
    .GUARD_CLKS (GUARD_CLKS),
    .EN_HOLD    (EN_HOLD)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .grant_id  (grant_id),
    .busy      (busy),
    .uart_en   (uart_en),
    .uart_din  (uart_din)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- behavioural uart_send (8N1, rising-edge uart_en start) ----------
  logic        en_d1, en_d2, tx_flag, uart_txd;
  logic [7:0]  tx_data;
  logic [15:0] clk_cnt;
  logic [3:0]  bit_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_d1 <= 1'b0; en_d2 <= 1'b0; tx_flag <= 1'b0;
      tx_data <= '0; clk_cnt <= '0; bit_cnt <= '0;
    end else begin
      en_d1 <= uart_en;
      en_d2 <= en_d1;
      if (en_d1 && !en_d2) begin
        tx_flag <= 1'b1; tx_data <= uart_din; clk_cnt <= '0; bit_cnt <= '0;
      end else if (tx_flag) begin
        if (clk_cnt == BPS_CNT - 16'd1) begin
          clk_cnt <= '0;
          if (bit_cnt == 4'd9) tx_flag <= 1'b0;
          else                 bit_cnt <= bit_cnt + 4'd1;
        end else begin
          clk_cnt <= clk_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)            uart_txd <= 1'b1;
    else if (!tx_flag)         uart_txd <= 1'b1;
    else if (bit_cnt == 4'd0)  uart_txd <= 1'b0;
    else if (bit_cnt <= 4'd8)  uart_txd <= tx_data[3'(bit_cnt - 4'd1)];
    else                       uart_txd <= 1'b1;
  end

  // ---------------- serial receiver: samples mid-bit, drops frames cut by reset --------
  initial begin : serial_monitor
    logic [7:0] sh;
    logic       st, sp;
    bit         aborted;
    forever begin
      @(negedge uart_txd);
      aborted = 1'b0; st = 1'b1; sp = 1'b0; sh = '0;
      for (int c = 1; c <= BPS / 2 + 9 * BPS; c++) begin
        @(posedge sys_clk);
        if (!sys_rst_n) begin aborted = 1'b1; break; end
        if (c == BPS / 2) st = uart_txd;
        else if (c > BPS / 2 && ((c - BPS / 2) % BPS) == 0) begin
          if ((c - BPS / 2) / BPS <= 8) sh = {uart_txd, sh[7:1]};
          else                          sp = uart_txd;
        end
      end
      if (!aborted) begin
        rx_q.push_back(sh); rx_start_q.push_back(st); rx_stop_q.push_back(sp);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model and stimulus helpers ----------------
  // Winner is the nearest set request bit strictly after the last served index, mod 4.
  function automatic int model_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
    return d[8 * i +: 8];
  endfunction

  task automatic do_reset();
    sys_rst_n = 1'b0;
    req = 4'b0000;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_rr = 3;
  endtask

  task automatic clear_rx();
    rx_q.delete(); rx_start_q.delete(); rx_stop_q.delete();
  endtask

  task automatic wait_ack(input int max_cyc, output logic [3:0] a, output logic [1:0] g,
                          output logic [7:0] d, output int waited);
    a = '0; g = '0; d = '0; waited = 0;
    while (waited < max_cyc) begin
      @(negedge sys_clk);
      waited++;
      if (ack != 4'b0000) begin
        a = ack; g = grant_id; d = uart_din;
        return;
      end
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && busy !== 1'b0; i++) @(negedge sys_clk);
  endtask

  task automatic wait_rx(input int n, input int max_cyc);
    for (int i = 0; i < max_cyc && rx_q.size() < n; i++) @(negedge sys_clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sys_rst_n = 1'b0; req = 4'b0000; req_data = $urandom;
    @(negedge sys_clk);
    checks++;
    if ({ack, grant_id, busy, uart_en, uart_din} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b gid=%0d busy=%b en=%b din=%h expected all zero",
               ack, grant_id, busy, uart_en, uart_din);
    end
    checks++;
    if (uart_txd !== 1'b1) begin
      errors++; $display("FAIL reset_txd: got %b expected 1", uart_txd);
    end
    sys_rst_n = 1'b1; model_rr = 3;
    repeat (5) @(negedge sys_clk);
    checks++;
    if ({ack, grant_id, busy, uart_en, uart_din} !== 16'h0000) begin
      errors++;
      $display("FAIL idle_no_req: got ack=%b gid=%0d busy=%b en=%b din=%h expected all zero",
               ack, grant_id, busy, uart_en, uart_din);
    end
  endtask

  task automatic test_single();
    logic [3:0] a; logic [1:0] g; logic [7:0] d; int w;
    int en_cnt, busy_cnt, extra_ack;
    clear_rx();
    req_data = $urandom; req_data[7:0] = 8'h55;
    req = 4'b0001;
    wait_ack(10, a, g, d, w);
    checks++;
    if (a !== 4'b0001 || w != 1) begin
      errors++; $display("FAIL t1_ack: got ack=%b after %0d cycles expected 0001 after 1", a, w);
    end
    checks++;
    if (g !== 2'd0 || d !== 8'h55) begin
      errors++; $display("FAIL t1_capture: got gid=%0d din=%h expected 0 55", g, d);
    end
    model_rr = 0;
    req = 4'b0000;
    en_cnt = (uart_en === 1'b1) ? 1 : 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    extra_ack = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (ack !== 4'b0000) extra_ack++;
      if (busy !== 1'b1) break;
      busy_cnt++;
      if (uart_en === 1'b1) en_cnt++;
    end
    checks++;
    if (en_cnt != 2 || extra_ack != 0) begin
      errors++; $display("FAIL t1_en_pulse: got en=%0d cycles, %0d extra acks expected 2, 0",
                         en_cnt, extra_ack);
    end
    checks++;
    if (busy_cnt != FRAME) begin
      errors++; $display("FAIL t1_busy_len: got %0d expected %0d", busy_cnt, FRAME);
    end
    wait_rx(1, 200);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55 || rx_start_q[0] !== 1'b0 || rx_stop_q[0] !== 1'b1) begin
      errors++; $display("FAIL t1_serial: got %0d frames first=%h expected one frame 55", rx_q.size(),
                         rx_q.size() > 0 ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_all_four();
    logic [3:0] a; logic [1:0] g; logic [7:0] d; int w, exp;
    do_reset();
    clear_rx();
    req_data = 32'hA3A2A1A0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(200, a, g, d, w);
      exp = model_pick(4'b1111, model_rr);
      checks++;
      if (a !== 4'(1 << exp) || g !== 2'(exp) || d !== byte_of(req_data, exp) ||
          w != ((i == 0) ? 1 : FRAME + 1)) begin
        errors++;
        $display("FAIL t2_grant%0d: got ack=%b gid=%0d din=%h gap=%0d expected gid=%0d din=%h gap=%0d",
                 i, a, g, d, w, exp, byte_of(req_data, exp), (i == 0) ? 1 : FRAME + 1);
      end
      model_rr = exp;
      if (i == 3) req = 4'b0000;
    end
    wait_idle(200);
    wait_rx(4, 200);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q.size() <= i || rx_q[i] !== byte_of(req_data, i) || rx_stop_q[i] !== 1'b1) begin
        errors++; $display("FAIL t2_serial%0d: got %h expected %h", i,
                           rx_q.size() > i ? rx_q[i] : 8'hxx, byte_of(req_data, i));
      end
    end
  endtask

  task automatic test_alternate();
    logic [3:0] a; logic [1:0] g; logic [7:0] d; int w, exp;
    logic [7:0] exp_bytes[$];
    do_reset();
    clear_rx();
    req_data = $urandom;
    req = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      wait_ack(200, a, g, d, w);
      exp = model_pick(4'b0101, model_rr);
      exp_bytes.push_back(byte_of(req_data, exp));
      checks++;
      if (a !== 4'(1 << exp) || d !== byte_of(req_data, exp) || w != ((i == 0) ? 1 : FRAME + 1)) begin
        errors++;
        $display("FAIL t3_grant%0d: got ack=%b din=%h gap=%0d expected requester %0d din=%h",
                 i, a, d, w, exp, byte_of(req_data, exp));
      end
      model_rr = exp;
      if (i == 5) req = 4'b0000;
    end
    wait_idle(200);
    wait_rx(6, 200);
    checks++;
    if (rx_q.size() != 6 || rx_q != exp_bytes) begin
      errors++; $display("FAIL t3_serial: got %0d bytes expected 6 matching grants", rx_q.size());
    end
  endtask

  task automatic test_late_request();
    logic [3:0] a; logic [1:0] g; logic [7:0] d; int w, early, exp;
    clear_rx();
    req_data = $urandom;
    req = 4'b0001;
    exp = model_pick(4'b0001, model_rr);
    wait_ack(10, a, g, d, w);
    checks++;
    if (a !== 4'(1 << exp) || w != 1) begin
      errors++; $display("FAIL t4_first: got ack=%b after %0d expected requester %0d after 1", a, w, exp);
    end
    model_rr = exp;
    req = 4'b0000;
    repeat (30) @(negedge sys_clk);
    req = 4'b1000;
    early = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (ack !== 4'b0000) early++;
      if (busy !== 1'b1) break;
    end
    checks++;
    if (early != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL t4_no_early_ack: got %0d early acks busy=%b expected 0 acks busy=0",
                         early, busy);
    end
    exp = model_pick(4'b1000, model_rr);
    wait_ack(10, a, g, d, w);
    checks++;
    if (a !== 4'(1 << exp) || g !== 2'(exp) || w != 1 || d !== byte_of(req_data, exp)) begin
      errors++; $display("FAIL t4_late_ack: got ack=%b gid=%0d after %0d expected requester %0d after 1",
                         a, g, w, exp);
    end
    model_rr = exp;
    req = 4'b0000;
    wait_idle(200);
    wait_rx(2, 200);
    checks++;
    if (rx_q.size() != 2 || rx_q[1] !== byte_of(req_data, 3)) begin
      errors++; $display("FAIL t4_serial: got %0d bytes expected 2 ending %h", rx_q.size(),
                         byte_of(req_data, 3));
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] a; logic [1:0] g; logic [7:0] d; int w, exp;
    clear_rx();
    req_data = $urandom;
    req = 4'b0100;
    exp = model_pick(4'b0100, model_rr);
    wait_ack(10, a, g, d, w);
    checks++;
    if (a !== 4'(1 << exp)) begin
      errors++; $display("FAIL t5_first: got ack=%b expected requester %0d", a, exp);
    end
    req = 4'b0000;
    repeat (40) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, grant_id, busy, uart_en, uart_din} !== 16'h0000 || uart_txd !== 1'b1) begin
      errors++;
      $display("FAIL t5_reset_now: got busy=%b en=%b din=%h txd=%b expected 0 0 00 1",
               busy, uart_en, uart_din, uart_txd);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_rr = 3;
    req_data = $urandom;
    req = 4'b0010;
    exp = model_pick(4'b0010, model_rr);
    wait_ack(10, a, g, d, w);
    checks++;
    if (a !== 4'b0010 || g !== 2'd1 || w != 1 || d !== byte_of(req_data, exp)) begin
      errors++; $display("FAIL t5_after_release: got ack=%b gid=%0d after %0d expected 0010 1 after 1",
                         a, g, w);
    end
    model_rr = exp;
    req = 4'b0000;
    wait_idle(200);
    wait_rx(1, 200);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== byte_of(req_data, 1)) begin
      errors++; $display("FAIL t5_serial: got %0d bytes expected 1 byte %h", rx_q.size(),
                         byte_of(req_data, 1));
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a; logic [1:0] g; logic [7:0] d; int w, exp;
    logic [7:0] exp_bytes[$];
    clear_rx();
    req_data = $urandom;
    req_data[15:0] = 16'hFF00;
    req = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      exp = model_pick(req, model_rr);
      wait_ack(200, a, g, d, w);
      checks++;
      if (a !== 4'(1 << exp) || d !== byte_of(req_data, exp) || w != ((i == 0) ? 1 : FRAME + 1)) begin
        errors++; $display("FAIL t6_grant%0d: got ack=%b din=%h gap=%0d expected requester %0d",
                           i, a, d, w, exp);
      end
      exp_bytes.push_back(byte_of(req_data, exp));
      model_rr = exp;
      req[exp] = 1'b0;
    end
    wait_idle(200);
    wait_rx(2, 200);
    checks++;
    if (rx_q.size() != 2 || rx_q != exp_bytes) begin
      errors++; $display("FAIL t6_serial: got %0d bytes expected 2 matching grants", rx_q.size());
    end
    checks++;
    if (rx_q.size() != 2 || rx_start_q[0] !== 1'b0 || rx_start_q[1] !== 1'b0 ||
        rx_stop_q[0] !== 1'b1 || rx_stop_q[1] !== 1'b1) begin
      errors++; $display("FAIL t6_framing: got start/stop bits not 0/1 on %0d frames", rx_q.size());
    end
  endtask

  task automatic test_random();
    logic [3:0] a; logic [1:0] g; logic [7:0] d; int w, exp;
    logic [3:0] mask;
    logic [7:0] exp_bytes[$];
    clear_rx();
    for (int f = 0; f < 8; f++) begin
      mask = 4'($urandom_range(1, 15));
      req_data = $urandom;
      req = mask;
      exp = model_pick(mask, model_rr);
      wait_ack(10, a, g, d, w);
      checks++;
      if (a !== 4'(1 << exp) || g !== 2'(exp) || d !== byte_of(req_data, exp) || w != 1) begin
        errors++;
        $display("FAIL rand%0d: req=%b got ack=%b gid=%0d din=%h expected requester %0d din=%h",
                 f, mask, a, g, d, exp, byte_of(req_data, exp));
      end
      exp_bytes.push_back(byte_of(req_data, exp));
      model_rr = exp;
      req = 4'b0000;
      wait_idle(200);
    end
    wait_rx(8, 200);
    checks++;
    if (rx_q.size() != 8 || rx_q != exp_bytes) begin
      errors++; $display("FAIL rand_serial: got %0d bytes expected 8 matching grants", rx_q.size());
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    req = 4'b0000;
    req_data = '0;
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_late_request();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
